// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: bubble encoding, reset PC default, fetch FSM
// state encodings and the instruction/PC packet carried by the skid buffer.
package if_stage_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_pkt_t;

    // Redirect targets are forced onto a word boundary; there is no misalignment trap.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry instruction/PC holding buffer used while decode stalls the IF/ID register.
module if_skid_buffer
    import if_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic       i_clear,
    input  fetch_pkt_t i_pkt,
    output logic       o_valid,
    output fetch_pkt_t o_pkt
);

    logic       r_valid;
    fetch_pkt_t r_pkt;

    // Clear wins: a drain or a redirect empties the entry in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_pkt <= i_pkt;
        end
    end

    assign o_valid = r_valid;
    assign o_pkt   = r_pkt;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: one outstanding imem
// request, decode-resolved redirects, and a skid buffer for decode stalls.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP      = NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        IFWrite,
    input  logic        Branch,
    input  logic        Jump,
    input  logic [31:0] JumpAddr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction_id,
    output logic [31:0] PC_id,
    output logic        valid_id
);

    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_instr_id;
    logic [31:0] r_pc_id;
    logic        r_valid_id;

    logic        w_redirect;
    logic        w_accept;
    logic        w_buf_valid;
    fetch_pkt_t  w_buf_pkt;
    fetch_pkt_t  w_rsp_pkt;

    // A redirect only counts when decode holds a real instruction and is advancing.
    assign w_redirect = (Branch | Jump) & IFWrite & r_valid_id;
    assign w_accept   = (r_state == S_WAIT) & imem_rvalid & ~w_redirect;
    assign imem_req   = ~w_redirect & ~w_buf_valid &
                        ((r_state == S_REQ) | ((r_state == S_WAIT) & imem_rvalid & IFWrite));
    assign imem_addr  = r_pc;

    assign w_rsp_pkt.instr = imem_rdata;
    assign w_rsp_pkt.pc    = r_req_pc;

    if_skid_buffer u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_accept & ~IFWrite),
        .i_clear (IFWrite),
        .i_pkt   (w_rsp_pkt),
        .o_valid (w_buf_valid),
        .o_pkt   (w_buf_pkt)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_REQ: begin
                if (imem_req) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    w_state_nxt = imem_req ? S_WAIT : S_REQ;
                end else if (w_redirect) begin
                    w_state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rvalid) w_state_nxt = S_REQ;
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            if (w_redirect) begin
                r_pc <= align_word(JumpAddr);
            end else if (imem_req) begin
                r_pc <= r_pc + 32'd4;
            end
        end
    end

    // The issue address travels with the request so the response carries its own PC.
    always_ff @(posedge clk) begin
        if (imem_req) begin
            r_req_pc <= r_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instr_id <= NOP;
            r_pc_id    <= 32'd0;
            r_valid_id <= 1'b0;
        end else if (IFWrite) begin
            if (w_redirect) begin
                r_instr_id <= NOP;
                r_valid_id <= 1'b0;
            end else if (w_buf_valid) begin
                r_instr_id <= w_buf_pkt.instr;
                r_pc_id    <= w_buf_pkt.pc;
                r_valid_id <= 1'b1;
            end else if (w_accept) begin
                r_instr_id <= imem_rdata;
                r_pc_id    <= r_req_pc;
                r_valid_id <= 1'b1;
            end else begin
                r_instr_id <= NOP;
                r_valid_id <= 1'b0;
            end
        end
    end

    assign Instruction_id = r_instr_id;
    assign PC_id          = r_pc_id;
    assign valid_id       = r_valid_id;

    a_no_rvalid_in_req: assert property (@(posedge clk) disable iff (!rst_n)
        !((r_state == S_REQ) && imem_rvalid));

endmodule
